// File: rtl/proc_mem_router.sv
// proc_mem_router
//   Fans the Ethernet streamer's shared memory-access bus out to NUM_PROC
//   processor memory ports. Writes go to one processor (unicast) or to all of
//   them (broadcast). Read data from the selected processor comes back on a
//   fixed-latency path matched to the processors' BRAM read latency. A write
//   count, an XOR checksum and sticky error flags are kept for host-side
//   integrity checks.
//
// Ports
//   clk, rst                 single clock, synchronous active-high reset
//   eth_*                    shared access bus from the streamer
//   eth_from_proc_data       read data returned to the streamer
//   proc_addr/wdata/mem_sel  registered shared bus to every processor
//   proc_we, proc_eth_en     per-processor write enable and Ethernet grant
//   proc_rdata, proc_busy    per-processor read data and busy status
//   wr_count, wr_checksum    accepted writes / XOR of their data this transfer
//   err_busy, err_range      sticky error flags, cleared by err_clr
module proc_mem_router #(
  parameter int NUM_PROC     = 8,
  parameter int ADDR_WIDTH   = 11,
  parameter int DATA_WIDTH   = 60,
  parameter int READ_LATENCY = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_WIDTH-1:0]        eth_addr,
  input  logic [DATA_WIDTH-1:0]        eth_to_proc_data,
  input  logic                         eth_to_proc_we,
  input  logic [2:0]                   eth_proc_sel,
  input  logic [3:0]                   eth_mem_sel,
  input  logic                         eth_to_all_proc_en,
  input  logic                         eth_intr,
  output logic [DATA_WIDTH-1:0]        eth_from_proc_data,
  output logic [ADDR_WIDTH-1:0]        proc_addr,
  output logic [DATA_WIDTH-1:0]        proc_wdata,
  output logic [3:0]                   proc_mem_sel,
  output logic [NUM_PROC-1:0]          proc_we,
  output logic [NUM_PROC-1:0]          proc_eth_en,
  input  logic [NUM_PROC*DATA_WIDTH-1:0] proc_rdata,
  input  logic [NUM_PROC-1:0]          proc_busy,
  output logic [15:0]                  wr_count,
  output logic [DATA_WIDTH-1:0]        wr_checksum,
  output logic                         err_busy,
  output logic                         err_range,
  input  logic                         err_clr
);

  localparam logic [3:0] NP = 4'(NUM_PROC);

  logic [NUM_PROC-1:0] tgt;
  logic [NUM_PROC-1:0] we_mask;
  logic                sel_bad;
  logic                wr_accept;
  logic                busy_set;
  logic                range_set;
  logic                intr_q;
  logic                intr_rise;

  // select delay line: stage k holds eth_proc_sel from k+1 cycles ago, so the
  // last stage lines up with proc_rdata for the address registered back then
  logic [2:0] sel_pipe [READ_LATENCY+1];

  always_comb begin
    tgt = '0;
    // an out-of-range unicast select matches no index, leaving tgt empty
    for (int i = 0; i < NUM_PROC; i++) begin
      tgt[i] = eth_to_all_proc_en || (eth_proc_sel == 3'(i));
    end
    sel_bad   = !eth_to_all_proc_en && ({1'b0, eth_proc_sel} >= NP);
    we_mask   = eth_to_proc_we ? (tgt & ~proc_busy) : '0;
    // a broadcast counts once and is accepted if any target can take it
    wr_accept = |we_mask;
    busy_set  = eth_to_proc_we && |(tgt & proc_busy);
    range_set = (eth_to_proc_we || eth_intr) && sel_bad;
    intr_rise = eth_intr && !intr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      proc_addr    <= '0;
      proc_wdata   <= '0;
      proc_mem_sel <= '0;
      proc_we      <= '0;
      proc_eth_en  <= '0;
      wr_count     <= '0;
      wr_checksum  <= '0;
      err_busy     <= 1'b0;
      err_range    <= 1'b0;
      intr_q       <= 1'b0;
      for (int k = 0; k <= READ_LATENCY; k++) begin
        sel_pipe[k] <= '0;
      end
    end else begin
      proc_addr    <= eth_addr;
      proc_wdata   <= eth_to_proc_data;
      proc_mem_sel <= eth_mem_sel;
      proc_we      <= we_mask;
      proc_eth_en  <= eth_intr ? tgt : '0;
      intr_q       <= eth_intr;

      // a write accepted on the transfer's first cycle becomes its first event
      if (intr_rise) begin
        wr_count    <= wr_accept ? 16'd1 : 16'd0;
        wr_checksum <= wr_accept ? eth_to_proc_data : '0;
      end else if (wr_accept) begin
        if (wr_count != 16'hFFFF) begin
          wr_count <= wr_count + 16'd1;
        end
        wr_checksum <= wr_checksum ^ eth_to_proc_data;
      end

      // a new error outranks a simultaneous clear
      if (busy_set) begin
        err_busy <= 1'b1;
      end else if (err_clr) begin
        err_busy <= 1'b0;
      end
      if (range_set) begin
        err_range <= 1'b1;
      end else if (err_clr) begin
        err_range <= 1'b0;
      end

      sel_pipe[0] <= eth_proc_sel;
      for (int k = 1; k <= READ_LATENCY; k++) begin
        sel_pipe[k] <= sel_pipe[k-1];
      end
    end
  end

  // delayed selects beyond NUM_PROC match nothing and return zero
  always_comb begin
    eth_from_proc_data = '0;
    for (int i = 0; i < NUM_PROC; i++) begin
      if (sel_pipe[READ_LATENCY] == 3'(i)) begin
        eth_from_proc_data = proc_rdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: doc/proc_mem_router.md
Name: proc_mem_router

Overview:
- Sits directly downstream of the Ethernet/AXI streamer.
- Takes its single shared memory-access bus (eth_addr, eth_to_proc_data, eth_to_proc_we, eth_proc_sel, eth_mem_sel, eth_to_all_proc_en, eth_intr) and fans it out to NUM_PROC processor memory ports.
- Each write is delivered as a unicast or a broadcast.
- Read data from the selected processor is returned on a fixed-latency path matched to the processors' BRAM latency.
- Keeps a per-transfer write count, an XOR checksum and sticky error flags for host-side integrity checks.

Parameters:
- NUM_PROC, 8, number of processors; 1..8, because eth_proc_sel is 3 bits.
- ADDR_WIDTH, 11, memory word address width.
- DATA_WIDTH, 60, coefficient word width.
- READ_LATENCY, 2, processor BRAM read latency in cycles, counted from a registered proc_addr to valid proc_rdata; 1..4.

Ports:
- clk  in  1  single clock for the block and all processor memory ports.
- rst  in  1  synchronous, active-high reset.
- eth_addr  in  ADDR_WIDTH  word address from the streamer.
- eth_to_proc_data  in  DATA_WIDTH  write data.
- eth_to_proc_we  in  1  write strobe, one word per cycle.
- eth_proc_sel  in  3  target processor index.
- eth_mem_sel  in  4  target memory bank inside the processor.
- eth_to_all_proc_en  in  1  broadcast writes to all processors.
- eth_intr  in  1  high while a host transfer is active.
- eth_from_proc_data  out  DATA_WIDTH  read data back to the streamer.
- proc_addr  out  ADDR_WIDTH  shared, registered address to all processors.
- proc_wdata  out  DATA_WIDTH  shared, registered write data.
- proc_mem_sel  out  4  shared, registered bank select.
- proc_we  out  NUM_PROC  per-processor write enable.
- proc_eth_en  out  NUM_PROC  per-processor grant: memory port is owned by Ethernet.
- proc_rdata  in  NUM_PROC*DATA_WIDTH  read data; processor i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- proc_busy  in  NUM_PROC  processor i is computing and must not be written.
- wr_count  out  16  accepted write events in the current transfer.
- wr_checksum  out  DATA_WIDTH  XOR of all accepted write data in the current transfer.
- err_busy  out  1  sticky: a write targeted a busy processor.
- err_range  out  1  sticky: eth_proc_sel >= NUM_PROC on a unicast access.
- err_clr  in  1  clears both sticky error flags.

Behaviour:
- Reset values: every register to 0. This covers proc_addr, proc_wdata, proc_mem_sel, proc_we, proc_eth_en, wr_count, wr_checksum, err_busy, err_range, the select pipeline and the eth_intr edge register. eth_from_proc_data therefore reads processor 0 data after reset.
- Target set T per cycle:
  - eth_to_all_proc_en = 1: T = all NUM_PROC processors.
  - otherwise: T = {eth_proc_sel}, or empty if eth_proc_sel >= NUM_PROC.
- Input stage, 1 cycle latency: proc_addr, proc_wdata and proc_mem_sel register the eth_* values every cycle.
- proc_we[i] is registered as: eth_to_proc_we & (i in T) & !proc_busy[i]. proc_busy is sampled in the same cycle as the strobe.
- proc_eth_en[i] is registered as: eth_intr & (i in T).
- Write event: eth_to_proc_we = 1 with T non-empty. A broadcast counts as one event.
  - Accepted only if at least one target is not busy.
  - Accepted: wr_count += 1, saturating at 0xFFFF; wr_checksum ^= eth_to_proc_data.
  - Broadcast with some targets busy: the busy ones are skipped, the event is still accepted, err_busy is set.
- err_busy is set when any write targets a busy processor.
- err_range is set by any eth_to_proc_we, or by any eth_intr cycle, with unicast and eth_proc_sel >= NUM_PROC. The access is dropped and no proc_we bit rises.
- err_clr clears both flags. If a set and err_clr occur in the same cycle, set wins.
- Transfer start: on the rising edge of eth_intr (registered compare), wr_count and wr_checksum clear to 0.
  - If a write is accepted in that same cycle, it loads as the first event: wr_count = 1, wr_checksum = that data.
  - The counters hold their values after eth_intr falls, so the host can read them back.
- Read path:
  - eth_proc_sel is delayed through a register pipeline of depth 1 + READ_LATENCY.
  - eth_from_proc_data is a combinational mux of proc_rdata using the delayed select.
  - Total latency from eth_addr to eth_from_proc_data is exactly 1 + READ_LATENCY cycles.
  - The read mux ignores eth_to_all_proc_en.
  - A delayed select >= NUM_PROC returns 0.
- Mid-transfer processor change: the streamer increments eth_proc_sel at address 0x7FF. This is supported without bubbles: write enables switch target on the next cycle, and read data follows the delayed select.
- A processor holds proc_eth_en only while the streamer keeps eth_intr high. No arbitration or hold occurs inside this block.
- Reset mid-transfer: all outputs and counters return to their reset values on the next clock edge, and in-flight read selects are discarded.

Test Plan:
- Unicast write: sel=3, 4 writes 0x1,0x2,0x4,0x8 at addr 0..3 -> proc_we = 8'b0000_1000 one cycle after each strobe; wr_count = 4; wr_checksum = 0xF.
- Broadcast with busy: all_en=1, proc_busy = 8'h05, one write -> proc_we = 8'hFA; wr_count = 1; err_busy = 1.
- Read latency: READ_LATENCY=2; proc 5 model returns addr+0x100; drive addr 0x10 with sel=5 -> eth_from_proc_data = 0x110 exactly 3 cycles later.
- Sel wrap: sel switches 2->3 between back-to-back reads at 0x7FF and 0x000 -> consecutive outputs are proc2[0x7FF] then proc3[0x000], no gap.
- Range error: NUM_PROC=4, unicast write with sel=6 -> proc_we stays 0 and err_range = 1. Assert err_clr together with a new bad write -> err_range stays 1. err_clr alone -> err_range = 0.
- Transfer restart: end a transfer with wr_count=7, drop eth_intr, raise it again with a write 0xAB in the rising-edge cycle -> wr_count = 1, wr_checksum = 0xAB. Assert rst mid-transfer -> all outputs 0 on the next edge.
